// File: rtl/dma_pkg.sv
// dma_pkg: shared FSM state, default sizes and count-width helper for the DMA packet source
package dma_pkg;
  typedef enum logic [1:0] {DMA_IDLE, DMA_REQ, DMA_XFER} dma_state_e;
  localparam int DMA_DSIZE = 32;
  localparam int DMA_DEPTH = 16;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/dma_pkt_fifo.sv
// dma_pkt_fifo: circular {last, word} buffer with packet count, overflow drop and forced truncation
module dma_pkt_fifo import dma_pkg::*; #(
  parameter int DSIZE = DMA_DSIZE,
  parameter int DEPTH = DMA_DEPTH
) (
  input  logic                      p_clk,
  input  logic                      n_rst,
  input  logic                      wr_en,
  input  logic [DSIZE-1:0]          wr_data,
  input  logic                      wr_last,
  input  logic                      pop,
  output logic [DSIZE-1:0]          head_data,
  output logic                      head_last,
  output logic                      full,
  output logic [cnt_w(DEPTH)-1:0]   pkt_cnt,
  output logic                      ovf,
  output logic                      trunc
);
  localparam int CW = cnt_w(DEPTH);
  localparam int AW = $clog2(DEPTH);
  logic [DSIZE:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic push, cut, in_last;
  assign full = count == CW'(DEPTH);
  assign push = wr_en && !full;
  // An oversized packet filling the buffer with nothing sendable would deadlock; close it here.
  assign cut = push && !wr_last && count == CW'(DEPTH - 1) && pkt_cnt == '0;
  assign in_last = wr_last || cut;
  assign head_data = mem[rptr][DSIZE-1:0];
  assign head_last = mem[rptr][DSIZE];
  always_ff @(posedge p_clk)
    if (push) mem[wptr] <= {in_last, wr_data};
  always_ff @(posedge p_clk or negedge n_rst)
    if (!n_rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      pkt_cnt <= '0;
      ovf <= 1'b0;
      trunc <= 1'b0;
    end else begin
      wptr <= wptr + AW'(push);
      rptr <= rptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
      pkt_cnt <= pkt_cnt + CW'(push && in_last) - CW'(pop && head_last);
      ovf <= wr_en && full;
      trunc <= cut;
    end
endmodule

// File: rtl/dma_pkt_src.sv
// dma_pkt_src: queues pushed packets and presents them to the bus arbiter over req/grant/ready
module dma_pkt_src import dma_pkg::*; #(
  parameter int DSIZE = DMA_DSIZE,
  parameter int DEPTH = DMA_DEPTH
) (
  input  logic                      p_clk,
  input  logic                      n_rst,
  input  logic                      en,
  input  logic                      burst,
  input  logic                      wr_en,
  input  logic [DSIZE-1:0]          wr_data,
  input  logic                      wr_last,
  output logic                      full,
  output logic [cnt_w(DEPTH)-1:0]   pkt_cnt,
  output logic                      ovf,
  output logic                      trunc,
  output logic                      req,
  input  logic                      grant,
  input  logic                      ready,
  output logic [DSIZE-1:0]          data,
  output logic                      pkt_end
);
  localparam int CW = cnt_w(DEPTH);
  dma_state_e state, state_n;
  logic xfer, keep, done, head_last;
  logic [DSIZE-1:0] head_data;
  assign xfer = state == DMA_XFER && grant && ready;
  assign keep = burst && en && pkt_cnt > CW'(1);
  assign done = xfer && head_last && !keep;
  dma_pkt_fifo #(.DSIZE(DSIZE), .DEPTH(DEPTH)) u_fifo (
    .p_clk(p_clk), .n_rst(n_rst), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .pop(xfer), .head_data(head_data), .head_last(head_last), .full(full),
    .pkt_cnt(pkt_cnt), .ovf(ovf), .trunc(trunc)
  );
  always_ff @(posedge p_clk or negedge n_rst)
    if (!n_rst) state <= DMA_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = DMA_IDLE;
    case (state)
      DMA_IDLE: state_n = en && pkt_cnt != '0 ? DMA_REQ : DMA_IDLE;
      DMA_REQ:  state_n = grant ? DMA_XFER : DMA_REQ;
      DMA_XFER: state_n = done ? DMA_IDLE : DMA_XFER;
      default:  state_n = DMA_IDLE;
    endcase
  end
  // req falls in the same cycle the closing word moves, so the arbiter can re-grant at once
  always_comb begin
    req = state == DMA_REQ || (state == DMA_XFER && !done);
    data = state == DMA_XFER ? head_data : '0;
    pkt_end = state == DMA_XFER && head_last;
  end
endmodule

// File: tb/tb_dma_pkt_src.sv
// tb_dma_pkt_src: vector table, directed corner sequences and a randomized queue-based reference model
module tb_dma_pkt_src;
  localparam int DSIZE = 32;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH + 1);
  logic p_clk = 0, n_rst = 0, en = 0, burst = 0, wr_en = 0, wr_last = 0, grant = 0, ready = 0;
  logic [DSIZE-1:0] wr_data = '0;
  logic full, ovf, trunc, req, pkt_end;
  logic [CW-1:0] pkt_cnt;
  logic [DSIZE-1:0] data;
  int vecs = 0, errs = 0;

  typedef struct {
    logic e, b, w, l, g, r;
    logic [DSIZE-1:0] d;
    logic q, pe;
    logic [DSIZE-1:0] dt;
    int c;
  } vec_t;
  vec_t tv[$];

  logic [DSIZE:0] mq[$];
  logic [DSIZE:0] hd;
  logic asking, owning, p_ovf, p_trunc, x, cont, fin;
  int npk, sz;

  always #5 p_clk = ~p_clk;

  dma_pkt_src #(.DSIZE(DSIZE), .DEPTH(DEPTH)) dut (
    .p_clk(p_clk), .n_rst(n_rst), .en(en), .burst(burst), .wr_en(wr_en), .wr_data(wr_data),
    .wr_last(wr_last), .full(full), .pkt_cnt(pkt_cnt), .ovf(ovf), .trunc(trunc), .req(req),
    .grant(grant), .ready(ready), .data(data), .pkt_end(pkt_end)
  );

  function automatic vec_t mk(input logic e, b, w, l, g, r, input logic [DSIZE-1:0] d,
                              input logic q, pe, input logic [DSIZE-1:0] dt, input int c);
    vec_t v;
    v.e = e; v.b = b; v.w = w; v.l = l; v.g = g; v.r = r; v.d = d;
    v.q = q; v.pe = pe; v.dt = dt; v.c = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DSIZE-1:0] act, input logic [DSIZE-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic setin(input logic e, b, w, l, g, r, input logic [DSIZE-1:0] d);
    en = e; burst = b; wr_en = w; wr_last = l; grant = g; ready = r; wr_data = d;
  endtask

  task automatic step();
    @(posedge p_clk);
    #1;
  endtask

  task automatic reset_dut();
    n_rst = 0;
    setin(0, 0, 0, 0, 0, 0, '0);
    repeat (2) @(posedge p_clk);
    #1 n_rst = 1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // single packet, then a backpressured 4-word packet with a 2-cycle grant gap
    tv.push_back(mk(1,0,1,0,0,1,32'hA1, 0,0,0,0));
    tv.push_back(mk(1,0,1,0,0,1,32'hA2, 0,0,0,0));
    tv.push_back(mk(1,0,1,1,0,1,32'hA3, 0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,1,0,      0,0,0,1));
    tv.push_back(mk(1,0,0,0,0,1,0,      1,0,0,1));
    tv.push_back(mk(1,0,0,0,1,1,0,      1,0,0,1));
    tv.push_back(mk(1,0,0,0,1,1,0,      1,0,32'hA1,1));
    tv.push_back(mk(1,0,0,0,1,1,0,      1,0,32'hA2,1));
    tv.push_back(mk(1,0,0,0,1,1,0,      0,1,32'hA3,1));
    tv.push_back(mk(1,0,0,0,0,0,0,      0,0,0,0));
    tv.push_back(mk(1,0,1,0,0,0,32'hB1, 0,0,0,0));
    tv.push_back(mk(1,0,1,0,0,0,32'hB2, 0,0,0,0));
    tv.push_back(mk(1,0,1,0,0,0,32'hB3, 0,0,0,0));
    tv.push_back(mk(1,0,1,1,0,0,32'hB4, 0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,      0,0,0,1));
    tv.push_back(mk(1,0,0,0,1,0,0,      1,0,0,1));
    tv.push_back(mk(1,0,0,0,1,1,0,      1,0,32'hB1,1));
    tv.push_back(mk(1,0,0,0,1,0,0,      1,0,32'hB2,1));
    tv.push_back(mk(1,0,0,0,1,0,0,      1,0,32'hB2,1));
    tv.push_back(mk(1,0,0,0,1,1,0,      1,0,32'hB2,1));
    tv.push_back(mk(1,0,0,0,0,1,0,      1,0,32'hB3,1));
    tv.push_back(mk(1,0,0,0,0,1,0,      1,0,32'hB3,1));
    tv.push_back(mk(1,0,0,0,1,1,0,      1,0,32'hB3,1));
    tv.push_back(mk(1,0,0,0,1,1,0,      0,1,32'hB4,1));
    tv.push_back(mk(1,0,0,0,0,0,0,      0,0,0,0));

    reset_dut();
    @(negedge p_clk);
    chk("rst req", req, 0);
    chk("rst data", data, 0);
    chk("rst pkt_end", pkt_end, 0);
    chk("rst full", full, 0);
    chk("rst pkt_cnt", pkt_cnt, 0);
    chk("rst ovf", ovf, 0);
    chk("rst trunc", trunc, 0);
    step();

    foreach (tv[i]) begin
      setin(tv[i].e, tv[i].b, tv[i].w, tv[i].l, tv[i].g, tv[i].r, tv[i].d);
      @(negedge p_clk);
      chk($sformatf("vec%0d req", i), req, tv[i].q);
      chk($sformatf("vec%0d data", i), data, tv[i].dt);
      chk($sformatf("vec%0d pkt_end", i), pkt_end, tv[i].pe);
      chk($sformatf("vec%0d pkt_cnt", i), pkt_cnt, tv[i].c);
      step();
    end

    // packets of 2 and 3 words, first with burst=1 then with burst=0
    for (int bm = 1; bm >= 0; bm--) begin
      reset_dut();
      for (int i = 0; i < 5; i++) begin
        setin(0, bm[0], 1, i == 1 || i == 4, 1, 1, 32'hC0 + i);
        step();
      end
      setin(1, bm[0], 0, 0, 1, 1, '0);
      @(negedge p_clk);
      chk("burst idle req", req, 0);
      chk("burst idle cnt", pkt_cnt, 2);
      step();
      @(negedge p_clk);
      chk("burst reqst req", req, 1);
      chk("burst reqst data", data, 0);
      step();
      if (bm == 1) begin
        for (int j = 0; j < 5; j++) begin
          @(negedge p_clk);
          chk($sformatf("burst w%0d data", j), data, 32'hC0 + j);
          chk($sformatf("burst w%0d pkt_end", j), pkt_end, j == 1 || j == 4);
          chk($sformatf("burst w%0d req", j), req, j != 4);
          step();
        end
      end else begin
        for (int j = 0; j < 7; j++) begin
          @(negedge p_clk);
          case (j)
            0: chk("nob w0 data", data, 32'hC0);
            1: begin chk("nob w1 data", data, 32'hC1); chk("nob w1 req", req, 0); end
            2: begin chk("nob gap req", req, 0); chk("nob gap cnt", pkt_cnt, 1); end
            3: begin chk("nob reqst req", req, 1); chk("nob reqst data", data, 0); end
            4: chk("nob w2 data", data, 32'hC2);
            5: chk("nob w3 data", data, 32'hC3);
            default: begin chk("nob w4 data", data, 32'hC4); chk("nob w4 req", req, 0); end
          endcase
          step();
        end
      end
      @(negedge p_clk);
      chk("burst end req", req, 0);
      chk("burst end cnt", pkt_cnt, 0);
      step();
    end

    // overflow and truncation of an oversized packet
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      setin(0, 0, 1, 0, 0, 0, 32'hD0 + i);
      @(negedge p_clk);
      chk($sformatf("ovf c%0d full", i), full, i >= 8);
      chk($sformatf("ovf c%0d trunc", i), trunc, i == 8);
      chk($sformatf("ovf c%0d ovf", i), ovf, i == 9);
      chk($sformatf("ovf c%0d cnt", i), pkt_cnt, i >= 8);
      step();
    end
    setin(0, 0, 0, 0, 0, 0, '0);
    @(negedge p_clk);
    chk("ovf c10 ovf", ovf, 1);
    chk("ovf c10 trunc", trunc, 0);
    step();
    setin(1, 0, 0, 0, 1, 1, '0);
    @(negedge p_clk);
    chk("ovf c11 ovf", ovf, 0);
    step();
    @(negedge p_clk);
    chk("ovf reqst req", req, 1);
    step();
    for (int j = 0; j < 8; j++) begin
      @(negedge p_clk);
      chk($sformatf("ovf drain w%0d data", j), data, 32'hD0 + j);
      chk($sformatf("ovf drain w%0d pkt_end", j), pkt_end, j == 7);
      step();
    end
    @(negedge p_clk);
    chk("ovf drained cnt", pkt_cnt, 0);
    chk("ovf drained full", full, 0);
    chk("ovf drained req", req, 0);

    // last word pushed while another packet's last word transfers
    reset_dut();
    setin(0, 0, 1, 0, 0, 0, 32'hF0);
    step();
    setin(0, 0, 1, 1, 0, 0, 32'hF1);
    step();
    setin(1, 0, 0, 0, 1, 1, '0);
    @(negedge p_clk);
    chk("pp cnt before", pkt_cnt, 1);
    step();
    @(negedge p_clk);
    chk("pp reqst req", req, 1);
    step();
    @(negedge p_clk);
    chk("pp w0 data", data, 32'hF0);
    step();
    setin(1, 0, 1, 1, 1, 1, 32'hE0);
    @(negedge p_clk);
    chk("pp w1 data", data, 32'hF1);
    chk("pp w1 pkt_end", pkt_end, 1);
    step();
    setin(0, 0, 0, 0, 1, 1, '0);
    @(negedge p_clk);
    chk("pp cnt after", pkt_cnt, 1);
    chk("pp req after", req, 0);

    // push rejected while full even though a pop happens that cycle
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      setin(0, 0, 1, i == 7, 0, 0, 32'h70 + i);
      step();
    end
    setin(1, 0, 0, 0, 1, 1, '0);
    @(negedge p_clk);
    chk("fp full", full, 1);
    chk("fp cnt", pkt_cnt, 1);
    chk("fp trunc", trunc, 0);
    step();
    step();
    setin(1, 0, 1, 0, 1, 1, 32'hDEAD);
    @(negedge p_clk);
    chk("fp pop full", full, 1);
    chk("fp w0 data", data, 32'h70);
    step();
    setin(1, 0, 0, 0, 1, 1, '0);
    for (int j = 1; j < 8; j++) begin
      @(negedge p_clk);
      if (j == 1) begin chk("fp ovf", ovf, 1); chk("fp full after", full, 0); end
      chk($sformatf("fp w%0d data", j), data, 32'h70 + j);
      chk($sformatf("fp w%0d pkt_end", j), pkt_end, j == 7);
      step();
    end
    @(negedge p_clk);
    chk("fp end cnt", pkt_cnt, 0);
    chk("fp end full", full, 0);

    // asynchronous reset in the middle of a transfer
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      setin(0, 0, 1, i == 3, 0, 0, 32'h50 + i);
      step();
    end
    setin(1, 0, 0, 0, 1, 1, '0);
    step();
    step();
    for (int j = 0; j < 2; j++) begin
      @(negedge p_clk);
      chk($sformatf("rx w%0d data", j), data, 32'h50 + j);
      step();
    end
    #1;
    chk("rx w2 data", data, 32'h52);
    chk("rx w2 req", req, 1);
    n_rst = 0;
    #1;
    chk("rx async req", req, 0);
    chk("rx async data", data, 0);
    chk("rx async pkt_end", pkt_end, 0);
    chk("rx async cnt", pkt_cnt, 0);
    step();
    step();
    n_rst = 1;
    for (int j = 0; j < 4; j++) begin
      @(negedge p_clk);
      chk($sformatf("rx post%0d req", j), req, 0);
      chk($sformatf("rx post%0d cnt", j), pkt_cnt, 0);
      step();
    end

    // randomized traffic against a queue model
    reset_dut();
    mq.delete();
    asking = 0; owning = 0; p_ovf = 0; p_trunc = 0;
    for (int c = 0; c < 1500; c++) begin
      setin($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            DSIZE'($urandom));
      @(negedge p_clk);
      npk = 0;
      foreach (mq[k]) npk += int'(mq[k][DSIZE]);
      sz = mq.size();
      hd = sz != 0 ? mq[0] : '0;
      x = owning && grant && ready;
      cont = burst && en && npk > 1;
      fin = x && hd[DSIZE] && !cont;
      chk($sformatf("rnd%0d req", c), req, asking || (owning && !fin));
      chk($sformatf("rnd%0d data", c), data, owning ? hd[DSIZE-1:0] : '0);
      chk($sformatf("rnd%0d pkt_end", c), pkt_end, owning && hd[DSIZE]);
      chk($sformatf("rnd%0d full", c), full, sz == DEPTH);
      chk($sformatf("rnd%0d pkt_cnt", c), pkt_cnt, npk);
      chk($sformatf("rnd%0d ovf", c), ovf, p_ovf);
      chk($sformatf("rnd%0d trunc", c), trunc, p_trunc);
      p_ovf = wr_en && sz == DEPTH;
      p_trunc = wr_en && sz == DEPTH - 1 && npk == 0 && !wr_last;
      if (owning) begin
        if (x) void'(mq.pop_front());
        if (fin) owning = 0;
      end else if (asking) begin
        if (grant) begin asking = 0; owning = 1; end
      end else if (en && npk != 0) asking = 1;
      if (wr_en && sz < DEPTH) mq.push_back({wr_last || p_trunc, wr_data});
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
